// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the async FIFO (write clock domain).
// Ports: clk, rst_n, winc, rptr_gray in; wclken, waddr, wptr_gray, wfull,
//        walmost_full, wlevel, woverflow out.
//        Optional sticky overflow flag: define FIFO_WR_OVERFLOW_EN.
module fifo_wr_ctrl #(
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH = FIFO_DEPTH - 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  wclken,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] level_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rq_gray;
    logic [PW-1:0] rq_bin;
    logic          full_next;

    // Enable depends only on registered full: no path from rptr_gray.
    assign wclken     = winc & ~wfull;
    assign waddr      = wbin[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin + PW'(wclken);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq_gray    = sync_q[SYNC_STAGES-1];

    // Gray to binary: each bit is the XOR of itself and all higher bits.
    always_comb begin
        rq_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    // Full when the write pointer is one lap ahead of the read pointer.
    assign full_next  = (wgray_next ==
                         {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
    assign level_next = wbin_next - rq_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr_gray    <= wgray_next;
            wfull        <= full_next;
            walmost_full <= (level_next >= AFULL_L);
            wlevel       <= level_next;
        end
    end

`ifdef FIFO_WR_OVERFLOW_EN
    logic ovf_q;

    // Sticky: any dropped write is remembered until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (winc & wfull) begin
            ovf_q <= 1'b1;
        end
    end

    assign woverflow = ovf_q;
`else
    assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl.
// Expected write addresses go through a scoreboard queue.
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       winc;
    logic [3:0] rptr_gray;
    logic       wclken;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       woverflow;

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q [$];
    logic ovf_exp;
    int w;

    fifo_wr_ctrl #(
        .FIFO_DEPTH  (8),
        .AFULL_THRESH(6),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .winc        (winc),
        .rptr_gray   (rptr_gray),
        .wclken      (wclken),
        .waddr       (waddr),
        .wptr_gray   (wptr_gray),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] g(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop();
        logic [2:0] e;
        chk("sb_size", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("waddr", 32'(waddr), 32'(e));
        end
    endtask

    // Drive one accepted write of expected address a; returns at edge+1.
    task automatic do_write(input int a);
        exp_q.push_back(3'(a));
        winc = 1'b1;
        #1;
        chk("wclken_on", 32'(wclken), 32'd1);
        sb_pop();
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wclken"}, 32'(wclken), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wptr"}, 32'(wptr_gray), 32'd0);
        chk({tag, "_wfull"}, 32'(wfull), 32'd0);
        chk({tag, "_afull"}, 32'(walmost_full), 32'd0);
        chk({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        chk({tag, "_ovf"}, 32'(woverflow), 32'd0);
    endtask

    initial begin
`ifdef FIFO_WR_OVERFLOW_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif
        rst_n     = 1'b0;
        winc      = 1'b0;
        rptr_gray = 4'b0000;
        #2;
        chk_zero("reset");
        #1 rst_n = 1'b1;
        tick();

        // Fill with read pointer at 0.
        for (int i = 0; i < 8; i++) begin
            chk("fill_level", 32'(wlevel), 32'(i));
            chk("fill_afull", 32'(walmost_full), 32'(i >= 6));
            chk("fill_full", 32'(wfull), 32'd0);
            do_write(i);
        end
        chk("full_flag", 32'(wfull), 32'd1);
        chk("full_afull", 32'(walmost_full), 32'd1);
        chk("full_level", 32'(wlevel), 32'd8);
        chk("full_wptr", 32'(wptr_gray), 32'hC);

        // Overflow: two blocked writes.
        winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ovf_wclken", 32'(wclken), 32'd0);
            chk("ovf_waddr", 32'(waddr), 32'd0);
            tick();
            chk("ovf_flag", 32'(woverflow), 32'(ovf_exp));
        end
        winc = 1'b0;
        tick();
        chk("ovf_sticky", 32'(woverflow), 32'(ovf_exp));
        chk("ovf_level", 32'(wlevel), 32'd8);
        chk("ovf_wptr", 32'(wptr_gray), 32'hC);

        // Drain visibility: reader at binary 3.
        rptr_gray = 4'b0010;
        tick();
        chk("drain_e1", 32'(wfull), 32'd1);
        tick();
        chk("drain_e2", 32'(wfull), 32'd1);
        chk("drain_e2_afull", 32'(walmost_full), 32'd1);
        tick();
        chk("drain_e3", 32'(wfull), 32'd0);
        chk("drain_e3_afull", 32'(walmost_full), 32'd0);
        chk("drain_level", 32'(wlevel), 32'd5);
        chk("drain_ovf", 32'(woverflow), 32'(ovf_exp));
        do_write(0);
        winc = 1'b0;
        chk("drain_wlevel", 32'(wlevel), 32'd6);
        chk("drain_wafull", 32'(walmost_full), 32'd1);

        // Reader catches up to 7 before the wrap run.
        rptr_gray = g(7);
        tick();
        tick();
        tick();
        chk("catch_level", 32'(wlevel), 32'd2);

        // Wrap-around: reader kept 2 entries behind for 20 writes.
        w = 9;
        for (int k = 0; k < 20; k++) begin
            rptr_gray = g(w - 2);
            do_write(w % 8);
            w++;
            chk("wrap_wptr", 32'(wptr_gray), 32'(g(w)));
            chk("wrap_full", 32'(wfull), 32'd0);
        end
        winc = 1'b0;
        tick();
        tick();
        tick();
        chk("wrap_level", 32'(wlevel), 32'd3);
        do_write(w % 8);
        w++;
        do_write(w % 8);
        w++;
        winc = 1'b0;
        chk("pre_rst_level", 32'(wlevel), 32'd5);

        // Short asynchronous reset pulse mid-operation.
        rst_n     = 1'b0;
        rptr_gray = 4'b0000;
        #1;
        chk_zero("midrst");
        #2 rst_n = 1'b1;
        tick();
        chk_zero("postrst");
        do_write(0);
        winc = 1'b0;
        chk("postrst_wptr", 32'(wptr_gray), 32'h1);
        chk("postrst_level", 32'(wlevel), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side controller for the asynchronous FIFO. It sits directly upstream of the FIFO storage array, in the write clock domain. It accepts write requests, drives the storage array's write-enable and write address, and maintains the binary and Gray write pointers. It synchronizes the read-domain Gray pointer and produces the full, almost-full and fill-level status.

## Interface

- FIFO_DEPTH, 8, number of storage entries; power of two, ≥ 4.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), storage address width; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, FIFO_DEPTH-2, level at or above which walmost_full asserts; range 1..FIFO_DEPTH.
- SYNC_STAGES, 2, flop stages on the incoming read pointer; ≥ 2.

- clk  in  1  write-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- winc  in  1  write request from the producer; data is presented to the storage array in the same cycle.
- rptr_gray  in  ADDR_WIDTH+1  Gray-coded read pointer from the read domain; asynchronous to clk.
- wclken  out  1  storage write enable; combinational, equal to winc & ~wfull.
- waddr  out  ADDR_WIDTH  storage write address; equal to the low bits of the binary write pointer.
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered; asserted when the level is ≥ AFULL_THRESH.
- wlevel  out  ADDR_WIDTH+1  registered fill level, range 0..FIFO_DEPTH, as seen from the write side.
- woverflow  out  1  sticky overflow error (see Configuration).

## Operation

**Pointer state**
- wbin is the binary write pointer, ADDR_WIDTH+1 bits.
- wptr_gray is registered as gray(wbin).
- The pointer advances only when wclken = 1.
- wbin_next = wbin + wclken, modulo 2^(ADDR_WIDTH+1).
- wgray_next = wbin_next ^ (wbin_next >> 1).

**Read-pointer synchronizer**
- rptr_gray passes through SYNC_STAGES flops, all reset to 0.
- The synchronizer output, rq_gray, is converted to binary as rq_bin using an XOR prefix chain.

**Full flag**
- wfull is registered with the value (wgray_next == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}).

**Level and almost-full**
- wlevel is registered with (wbin_next − rq_bin), modulo 2^(ADDR_WIDTH+1).
- walmost_full is registered with (that level ≥ AFULL_THRESH).

**Write acceptance and blocked writes**
- A write is accepted in any cycle with winc = 1 and wfull = 0.
- When winc = 1 and wfull = 1:
  - wclken = 0.
  - The pointers, waddr and the level hold.
  - The write is dropped, with no back-pressure beyond wfull.
- There is no internal state machine beyond the pointer and flag registers. All status is derived from the pointers every cycle.

**Pointer wrap-around**
- Wrap-around is natural modulo 2^(ADDR_WIDTH+1).
- The extra MSB distinguishes a full FIFO from an empty one.

**Boundary cases**
- A write that fills the last free entry sets wfull on the same edge that advances the pointer.
- Space freed by the reader and a simultaneous write in the same cycle: the write is evaluated against the current wfull. The new flags reflect both events, i.e. the newly written pointer and the latest rq_gray.
- Conservatism: the read pointer is stale by the synchronizer latency, so wfull and wlevel are pessimistic, never optimistic. The bench must not flag this as an error.

**Reset**
- Reset asserted mid-operation immediately clears all registers, asynchronously.
- Outputs reset values:
  - wclken = 0 while winc = 0.
  - waddr = 0, wptr_gray = 0, wfull = 0, walmost_full = 0, wlevel = 0, woverflow = 0.

## Timing

- wclken: zero-latency, combinational from winc and the registered wfull. There is no combinational path from rptr_gray.
- waddr and wptr_gray update on the rising edge that accepts a write.
- wfull, walmost_full and wlevel reflect an accepted write on that same edge.
- A rptr_gray change, stable before edge k, appears at rq_gray after edge k+SYNC_STAGES−1. wfull, walmost_full and wlevel reflect it after edge k+SYNC_STAGES (3 edges with the default settings).
- Throughput: one write per clk cycle while not full.

## Configuration

- Macro: FIFO_WR_OVERFLOW_EN.
- Defined:
  - woverflow is a register, reset to 0.
  - It is set on the edge after any cycle with winc = 1 and wfull = 1.
  - It stays set until rst_n is asserted.
- Undefined:
  - No overflow register is built.
  - woverflow is tied to 0.
  - Dropped writes go unreported.

## Test plan

Defaults for all scenarios: FIFO_DEPTH = 8, AFULL_THRESH = 6, SYNC_STAGES = 2.

- Reset state: assert rst_n = 0 with winc = 0 → all outputs 0, wptr_gray = 4'b0000.
- Fill: hold rptr_gray = 0 and apply winc for 8 cycles → waddr steps 0..7. walmost_full rises after the 6th write and wfull after the 8th. wlevel = 8, wptr_gray = 4'b1100.
- Overflow: keep winc = 1 for 2 more cycles while full → wclken = 0 and waddr holds at 0. woverflow = 1 with the macro defined and stays 0 without it. It remains set after winc drops.
- Drain visibility: when full, set rptr_gray = 4'b0010 (binary 3) → wfull and walmost_full fall on the 3rd edge. wlevel = 5. wclken re-enables when winc = 1.
- Wrap-around: keep the read pointer 2 entries behind while writing 20 entries → wptr_gray follows the Gray sequence through 4'b1000 → 4'b0000. wfull never falsely asserts and waddr wraps 7 → 0.
- Mid-operation reset: pulse rst_n low for less than one cycle at wlevel = 5 → all outputs clear immediately and stay cleared. The first subsequent write uses waddr = 0.
